// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request and response channels, word RAM with byte enables,
// configurable wait states. Optional macro DMEM_MISALIGN_ERR_EN turns misaligned accesses into errors.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [29:0]     word_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [29:0]     word_off;
    logic [ADDR_WIDTH-1:0] idx;
    logic            acc_err;
    logic            do_access;
    logic [31:0]     mem [0:(1 << ADDR_WIDTH) - 1];

    // Base is word aligned, so the offset is computed on word addresses; an
    // address below base wraps to a huge offset and lands out of range.
    assign word_off  = word_q - BASE_ADDR[31:2];
    assign idx       = word_off[ADDR_WIDTH-1:0];
    assign do_access = (state == BUSY) && (cnt == '0);

`ifdef DMEM_MISALIGN_ERR_EN
    logic mis_q;
    assign acc_err = (word_off[29:ADDR_WIDTH] != '0) || mis_q;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign acc_err = (word_off[29:ADDR_WIDTH] != '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        word_q    <= req_addr[31:2];
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
`ifdef DMEM_MISALIGN_ERR_EN
                        mis_q     <= (req_addr[1:0] != 2'b00);
`endif
                        cnt       <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || we_q) ? '0 : mem[idx];
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // RAM has no reset; a reset before the access edge leaves state != BUSY, so no write.
    always_ff @(posedge clk) begin
        if (do_access && we_q && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the multicycle RISC-V core (`top_proc`). It sits on the core's load/store port and answers each request through a valid/ready request channel and a valid/ready response channel. Wait states are configurable so the core's memory-stall handling is exercised. It holds a word-organised RAM, applies byte-enabled writes, and flags out-of-range accesses with an error response.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, default 32'h10010000: byte address of word 0; must be 4-byte aligned.
- `WAIT_CYCLES`, default 2: extra BUSY cycles per access, 0..15.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_be` in 4: byte enables; bit i enables byte i, which is `wdata[8i+7:8i]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: access error.

## Operation
States and transitions:
- **IDLE**
  - `req_ready` = 1. `req_ready` is decoded from state only and never depends on `req_valid`.
  - On `req_valid && req_ready`: capture `we`, `addr`, `wdata` and `be`; load `cnt` = WAIT_CYCLES; go to BUSY.
- **BUSY**
  - `req_ready` = 0.
  - If `cnt` != 0: decrement `cnt`.
  - If `cnt` == 0: perform the access, register `rsp_rdata` and `rsp_err`, go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_valid && rsp_ready`: go to IDLE.

Access rules:
- Offset = `addr` − BASE_ADDR, computed as a 32-bit unsigned value. Word index = offset[ADDR_WIDTH+1:2].
- Out of range (offset ≥ 4·2^ADDR_WIDTH; wrap-around of the subtraction covers addresses below base):
  - no RAM write;
  - `rsp_rdata` = 0, `rsp_err` = 1.
- Load: returns the full word regardless of `be`; `rsp_err` = 0.
- Store: writes only the enabled bytes; `rsp_rdata` = 0; `rsp_err` = 0.
  - `be` = 0 is a legal no-op store and still gets a normal response.
- The RAM is not reset. Contents are unknown until written; the bench must write before it reads.

## Timing
Reset values while `rst` is asserted, applied asynchronously:
- state = IDLE, `cnt` = 0.
- `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.

Latency:
- Request accepted at edge N: state is BUSY for W+1 cycles (W = WAIT_CYCLES).
- RAM write and response register update happen at edge N+W+1; `rsp_valid` is high from that edge on.
- A response accepted at edge M returns the block to IDLE; `req_ready` is 1 from edge M.
- Minimum period is W+3 cycles per request (W = 0 → 3 cycles). Only one request is outstanding; there is no pipelining.

Boundary conditions:
- `rsp_ready` held high in advance: the handshake completes at the first edge where `rsp_valid` is high.
- `rsp_ready` low: stall in RESP indefinitely with outputs constant.
- `req_valid` asserted in BUSY or RESP: ignored. The request must be held until IDLE.
- Reset mid-operation:
  - Asserted before edge N+W+1: the store is abandoned and RAM is unchanged.
  - Asserted after that edge: the write has already committed.
  - In either case the response is dropped.

## Configuration
Macro `DMEM_MISALIGN_ERR_EN`:
- **Defined:** an access with `addr[1:0]` != 0 is an error, with the same behaviour as out of range (no write, `rsp_rdata` = 0, `rsp_err` = 1). The error takes precedence, and latency is unchanged.
- **Undefined:** `addr[1:0]` is ignored and the access targets the aligned word containing `addr`.

## Test plan
- **Basic store then load.** Defaults. Store 32'hDEADBEEF to 32'h10010004 with `be` = 4'hF, then load the same address. Required: load returns 32'hDEADBEEF with `rsp_err` = 0; each `rsp_valid` rises 3 cycles after its accept edge.
- **Byte-enable store.** Store 32'h11223344 with `be` = 4'b0101 over 32'hDEADBEEF. Required: a subsequent load returns 32'hDE22BE44.
- **Out-of-range addresses.** Load from 32'h1000FFFC and from 32'h10011000. Required: `rsp_err` = 1 and `rsp_rdata` = 0 for both; RAM is unchanged.
- **Response backpressure and latency.** WAIT_CYCLES = 0, `rsp_ready` held low for 5 cycles. Required: `rsp_valid` stays high with stable data and `req_ready` stays 0; IDLE is reached at the first `rsp_ready` edge; latency is 1 cycle.
- **Reset mid-store.** Assert `rst` one cycle after accepting a store to 32'h10010008. Required: outputs take their reset values immediately, and a later load returns the old word.
- **Misaligned access.** Load from 32'h10010006. Required with `DMEM_MISALIGN_ERR_EN`: `rsp_err` = 1. Required without it: data from word 32'h10010004 is returned with `rsp_err` = 0.
